// File: rtl/pipe_id_ex.sv
// ID->EX pipeline register with load-use stall detection and flush/stall bubble insertion.
// Latency: one cycle from id_* to ex_*. Backpressure: stall_id is combinational and lasts one cycle per hazard.
// Optional bubble counter on cnt_bubble, enabled by defining PIPE_STAT_EN.
`ifndef IM_ADDR_BIT
`define IM_ADDR_BIT 32
`endif
`ifndef ALU_OP_BIT
`define ALU_OP_BIT 4
`endif
`ifndef WTG_OP_BIT
`define WTG_OP_BIT 3
`endif
`ifndef MUX_ALU_DATAY_BIT
`define MUX_ALU_DATAY_BIT 2
`endif

module pipe_id_ex (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          en,
    input  logic                          id_valid,
    input  logic [`IM_ADDR_BIT-1:0]       id_pc_4,
    input  logic [4:0]                    id_shamt,
    input  logic [15:0]                   id_imm16,
    input  logic [31:0]                   id_rf_data_a,
    input  logic [31:0]                   id_rf_data_b,
    input  logic [`ALU_OP_BIT-1:0]        id_ctl_alu_op,
    input  logic [`WTG_OP_BIT-1:0]        id_ctl_wtg_op,
    input  logic                          id_ctl_syscall_en,
    input  logic [`MUX_ALU_DATAY_BIT-1:0] id_mux_alu_data_y,
    input  logic                          id_ctl_mem_read,
    input  logic                          id_ctl_rf_we,
    input  logic [4:0]                    id_rs,
    input  logic [4:0]                    id_rt,
    input  logic [4:0]                    id_rd_dst,
    input  logic                          ex_branched,
    output logic                          ex_valid,
    output logic [`IM_ADDR_BIT-1:0]       ex_pc_4,
    output logic [4:0]                    ex_shamt,
    output logic [15:0]                   ex_imm16,
    output logic [31:0]                   ex_rf_data_a,
    output logic [31:0]                   ex_rf_data_b,
    output logic [`ALU_OP_BIT-1:0]        ex_ctl_alu_op,
    output logic [`WTG_OP_BIT-1:0]        ex_ctl_wtg_op,
    output logic                          ex_ctl_syscall_en,
    output logic [`MUX_ALU_DATAY_BIT-1:0] ex_mux_alu_data_y,
    output logic                          ex_ctl_mem_read,
    output logic                          ex_ctl_rf_we,
    output logic [4:0]                    ex_rs,
    output logic [4:0]                    ex_rt,
    output logic [4:0]                    ex_rd_dst,
    output logic                          stall_id,
    output logic [15:0]                   cnt_bubble
);

    typedef struct packed {
        logic [`IM_ADDR_BIT-1:0] pc_4;
        logic [4:0]              shamt;
        logic [15:0]             imm16;
        logic [31:0]             rf_data_a;
        logic [31:0]             rf_data_b;
        logic [4:0]              rs;
        logic [4:0]              rt;
        logic [4:0]              rd_dst;
    } dat_t;

    typedef struct packed {
        logic [`ALU_OP_BIT-1:0]        alu_op;
        logic [`WTG_OP_BIT-1:0]        wtg_op;
        logic                          syscall_en;
        logic [`MUX_ALU_DATAY_BIT-1:0] mux_alu_data_y;
        logic                          mem_read;
        logic                          rf_we;
    } ctl_t;

    logic vld_d, vld_q;
    dat_t dat_d, dat_q;
    ctl_t ctl_d, ctl_q;
    logic bubble;

    // $0 is hardwired, so a load targeting it can never feed a dependent instruction.
    assign stall_id = id_valid & vld_q & ctl_q.mem_read & (dat_q.rd_dst != 5'd0)
                    & ((dat_q.rd_dst == id_rs) | (dat_q.rd_dst == id_rt));

    assign bubble = ex_branched | stall_id;

    always_comb begin
        vld_d = vld_q;
        dat_d = dat_q;
        ctl_d = ctl_q;
        if (en) begin
            if (bubble) begin
                // All-zero control is a no-op; operand fields are left as they were.
                vld_d = 1'b0;
                ctl_d = '0;
            end else begin
                vld_d = id_valid;
                dat_d = '{pc_4: id_pc_4, shamt: id_shamt, imm16: id_imm16,
                          rf_data_a: id_rf_data_a, rf_data_b: id_rf_data_b,
                          rs: id_rs, rt: id_rt, rd_dst: id_rd_dst};
                ctl_d = '{alu_op: id_ctl_alu_op, wtg_op: id_ctl_wtg_op,
                          syscall_en: id_ctl_syscall_en, mux_alu_data_y: id_mux_alu_data_y,
                          mem_read: id_ctl_mem_read, rf_we: id_ctl_rf_we};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= 1'b0;
            dat_q <= '0;
            ctl_q <= '0;
        end else begin
            vld_q <= vld_d;
            dat_q <= dat_d;
            ctl_q <= ctl_d;
        end
    end

`ifdef PIPE_STAT_EN
    logic [15:0] cnt_d, cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (en && bubble && (cnt_q != 16'hFFFF)) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 16'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_bubble = cnt_q;
`else
    assign cnt_bubble = 16'd0;
`endif

    assign ex_valid          = vld_q;
    assign ex_pc_4           = dat_q.pc_4;
    assign ex_shamt          = dat_q.shamt;
    assign ex_imm16          = dat_q.imm16;
    assign ex_rf_data_a      = dat_q.rf_data_a;
    assign ex_rf_data_b      = dat_q.rf_data_b;
    assign ex_rs             = dat_q.rs;
    assign ex_rt             = dat_q.rt;
    assign ex_rd_dst         = dat_q.rd_dst;
    assign ex_ctl_alu_op     = ctl_q.alu_op;
    assign ex_ctl_wtg_op     = ctl_q.wtg_op;
    assign ex_ctl_syscall_en = ctl_q.syscall_en;
    assign ex_mux_alu_data_y = ctl_q.mux_alu_data_y;
    assign ex_ctl_mem_read   = ctl_q.mem_read;
    assign ex_ctl_rf_we      = ctl_q.rf_we;

endmodule

// File: tb/tb_pipe_id_ex.sv
// Directed bench for pipe_id_ex: reference model of the EX slot plus literal spot checks.
`ifndef IM_ADDR_BIT
`define IM_ADDR_BIT 32
`endif
`ifndef ALU_OP_BIT
`define ALU_OP_BIT 4
`endif
`ifndef WTG_OP_BIT
`define WTG_OP_BIT 3
`endif
`ifndef MUX_ALU_DATAY_BIT
`define MUX_ALU_DATAY_BIT 2
`endif

module tb_pipe_id_ex;

    logic clk = 1'b0;
    logic rst_n, en, id_valid, ex_branched;
    logic [`IM_ADDR_BIT-1:0] id_pc_4;
    logic [4:0] id_shamt, id_rs, id_rt, id_rd_dst;
    logic [15:0] id_imm16;
    logic [31:0] id_rf_data_a, id_rf_data_b;
    logic [`ALU_OP_BIT-1:0] id_ctl_alu_op;
    logic [`WTG_OP_BIT-1:0] id_ctl_wtg_op;
    logic id_ctl_syscall_en, id_ctl_mem_read, id_ctl_rf_we;
    logic [`MUX_ALU_DATAY_BIT-1:0] id_mux_alu_data_y;

    logic ex_valid, ex_ctl_syscall_en, ex_ctl_mem_read, ex_ctl_rf_we, stall_id;
    logic [`IM_ADDR_BIT-1:0] ex_pc_4;
    logic [4:0] ex_shamt, ex_rs, ex_rt, ex_rd_dst;
    logic [15:0] ex_imm16, cnt_bubble;
    logic [31:0] ex_rf_data_a, ex_rf_data_b;
    logic [`ALU_OP_BIT-1:0] ex_ctl_alu_op;
    logic [`WTG_OP_BIT-1:0] ex_ctl_wtg_op;
    logic [`MUX_ALU_DATAY_BIT-1:0] ex_mux_alu_data_y;

    int n_run = 0;
    int n_fail = 0;

    pipe_id_ex dut (
        .clk(clk), .rst_n(rst_n), .en(en), .id_valid(id_valid),
        .id_pc_4(id_pc_4), .id_shamt(id_shamt), .id_imm16(id_imm16),
        .id_rf_data_a(id_rf_data_a), .id_rf_data_b(id_rf_data_b),
        .id_ctl_alu_op(id_ctl_alu_op), .id_ctl_wtg_op(id_ctl_wtg_op),
        .id_ctl_syscall_en(id_ctl_syscall_en), .id_mux_alu_data_y(id_mux_alu_data_y),
        .id_ctl_mem_read(id_ctl_mem_read), .id_ctl_rf_we(id_ctl_rf_we),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd_dst(id_rd_dst),
        .ex_branched(ex_branched),
        .ex_valid(ex_valid), .ex_pc_4(ex_pc_4), .ex_shamt(ex_shamt), .ex_imm16(ex_imm16),
        .ex_rf_data_a(ex_rf_data_a), .ex_rf_data_b(ex_rf_data_b),
        .ex_ctl_alu_op(ex_ctl_alu_op), .ex_ctl_wtg_op(ex_ctl_wtg_op),
        .ex_ctl_syscall_en(ex_ctl_syscall_en), .ex_mux_alu_data_y(ex_mux_alu_data_y),
        .ex_ctl_mem_read(ex_ctl_mem_read), .ex_ctl_rf_we(ex_ctl_rf_we),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd_dst(ex_rd_dst),
        .stall_id(stall_id), .cnt_bubble(cnt_bubble)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the EX slot is the last instruction accepted; a bubble empties it
    // without touching operand fields.
    logic m_vld;
    logic [63:0] m_pc, m_shamt, m_imm, m_a, m_b, m_rs, m_rt, m_rd;
    logic [63:0] m_alu, m_wtg, m_sys, m_mux, m_mr, m_we;
    int m_cnt;

    function automatic logic m_hazard();
        return id_valid && m_vld && m_mr != 0 && m_rd != 0 &&
               (m_rd == 64'(id_rs) || m_rd == 64'(id_rt));
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_vld = 0; m_pc = 0; m_shamt = 0; m_imm = 0; m_a = 0; m_b = 0;
            m_rs = 0; m_rt = 0; m_rd = 0; m_alu = 0; m_wtg = 0; m_sys = 0;
            m_mux = 0; m_mr = 0; m_we = 0; m_cnt = 0;
        end else if (en) begin
            if (ex_branched || m_hazard()) begin
                m_vld = 0; m_alu = 0; m_wtg = 0; m_sys = 0; m_mux = 0; m_mr = 0; m_we = 0;
`ifdef PIPE_STAT_EN
                m_cnt = (m_cnt >= 65535) ? 65535 : m_cnt + 1;
`endif
            end else begin
                m_vld = id_valid; m_pc = 64'(id_pc_4); m_shamt = 64'(id_shamt);
                m_imm = 64'(id_imm16); m_a = 64'(id_rf_data_a); m_b = 64'(id_rf_data_b);
                m_rs = 64'(id_rs); m_rt = 64'(id_rt); m_rd = 64'(id_rd_dst);
                m_alu = 64'(id_ctl_alu_op); m_wtg = 64'(id_ctl_wtg_op);
                m_sys = 64'(id_ctl_syscall_en); m_mux = 64'(id_mux_alu_data_y);
                m_mr = 64'(id_ctl_mem_read); m_we = 64'(id_ctl_rf_we);
            end
        end
    end

    always @(negedge clk) begin
        chk("valid", 64'(ex_valid), 64'(m_vld));
        chk("pc_4", 64'(ex_pc_4), m_pc);
        chk("shamt", 64'(ex_shamt), m_shamt);
        chk("imm16", 64'(ex_imm16), m_imm);
        chk("data_a", 64'(ex_rf_data_a), m_a);
        chk("data_b", 64'(ex_rf_data_b), m_b);
        chk("rs", 64'(ex_rs), m_rs);
        chk("rt", 64'(ex_rt), m_rt);
        chk("rd_dst", 64'(ex_rd_dst), m_rd);
        chk("alu_op", 64'(ex_ctl_alu_op), m_alu);
        chk("wtg_op", 64'(ex_ctl_wtg_op), m_wtg);
        chk("syscall", 64'(ex_ctl_syscall_en), m_sys);
        chk("mux_y", 64'(ex_mux_alu_data_y), m_mux);
        chk("mem_read", 64'(ex_ctl_mem_read), m_mr);
        chk("rf_we", 64'(ex_ctl_rf_we), m_we);
        chk("stall_id", 64'(stall_id), 64'(rst_n && m_hazard()));
        chk("cnt_bubble", 64'(cnt_bubble), 64'(m_cnt));
    end

    // Inputs change 2 time units after the rising edge so every sample sees settled values.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input logic vld, input logic [31:0] pc, input logic [31:0] a,
                         input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                         input logic mr, input logic we);
        id_valid = vld; id_pc_4 = `IM_ADDR_BIT'(pc); id_rf_data_a = a;
        id_rf_data_b = a ^ 32'h5A5A_0000; id_shamt = pc[4:0]; id_imm16 = pc[15:0] + 16'h100;
        id_rs = rs; id_rt = rt; id_rd_dst = rd;
        id_ctl_mem_read = mr; id_ctl_rf_we = we;
        id_ctl_alu_op = `ALU_OP_BIT'(pc[5:2]); id_ctl_wtg_op = '0;
        id_ctl_syscall_en = 1'b0; id_mux_alu_data_y = `MUX_ALU_DATAY_BIT'(1);
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b1; ex_branched = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        tick(); tick();
        chk("rst_valid", 64'(ex_valid), 0);
        chk("rst_pc", 64'(ex_pc_4), 0);
        chk("rst_cnt", 64'(cnt_bubble), 0);
        rst_n = 1'b1;

        // Plain advance.
        drive(1, 32'h010, 32'h1234, 5'd1, 5'd2, 5'd3, 0, 1);
        tick();
        chk("adv_pc", 64'(ex_pc_4), 64'h010);
        chk("adv_a", 64'(ex_rf_data_a), 64'h1234);
        chk("adv_valid", 64'(ex_valid), 1);

        // Load-use hazard on rs.
        drive(1, 32'h014, 32'h0, 5'd0, 5'd0, 5'd8, 1, 1);
        tick();
        drive(1, 32'h018, 32'hBEEF, 5'd8, 5'd9, 5'd10, 0, 1);
        #1 chk("lu_stall", 64'(stall_id), 1);
        tick();
        chk("lu_bub_valid", 64'(ex_valid), 0);
        chk("lu_bub_mr", 64'(ex_ctl_mem_read), 0);
        chk("lu_bub_we", 64'(ex_ctl_rf_we), 0);
        chk("lu_bub_pc_hold", 64'(ex_pc_4), 64'h014);
        chk("lu_stall_clear", 64'(stall_id), 0);
`ifdef PIPE_STAT_EN
        chk("lu_cnt", 64'(cnt_bubble), 1);
`endif
        tick();
        chk("lu_after_pc", 64'(ex_pc_4), 64'h018);

        // Load to $0 never stalls.
        drive(1, 32'h01C, 32'h0, 5'd0, 5'd0, 5'd0, 1, 1);
        tick();
        drive(1, 32'h020, 32'h77, 5'd0, 5'd0, 5'd4, 0, 1);
        #1 chk("r0_stall", 64'(stall_id), 0);
        tick();
        chk("r0_pc", 64'(ex_pc_4), 64'h020);
        chk("r0_valid", 64'(ex_valid), 1);

        // Flush over a syscall.
        drive(1, 32'h024, 32'h99, 5'd1, 5'd1, 5'd1, 0, 1);
        id_ctl_syscall_en = 1'b1; id_ctl_wtg_op = `WTG_OP_BIT'(5); ex_branched = 1'b1;
        tick();
        ex_branched = 1'b0;
        chk("fl_valid", 64'(ex_valid), 0);
        chk("fl_sys", 64'(ex_ctl_syscall_en), 0);
        chk("fl_wtg", 64'(ex_ctl_wtg_op), 0);
        chk("fl_pc_hold", 64'(ex_pc_4), 64'h020);

        // Flush and stall together give one bubble.
        drive(1, 32'h028, 32'h0, 5'd0, 5'd0, 5'd8, 1, 1);
        tick();
        drive(1, 32'h02C, 32'h0, 5'd3, 5'd8, 5'd5, 0, 1);
        ex_branched = 1'b1;
        #1 chk("both_stall", 64'(stall_id), 1);
        tick();
        ex_branched = 1'b0;
        chk("both_valid", 64'(ex_valid), 0);
`ifdef PIPE_STAT_EN
        chk("both_cnt", 64'(cnt_bubble), 3);
`endif

        // Hold with en=0; stall_id still tracks the decode inputs.
        drive(1, 32'h040, 32'hCAFE, 5'd0, 5'd0, 5'd8, 1, 1);
        tick();
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1, 32'h100 + 32'(i), $urandom, (i == 1) ? 5'd8 : 5'd2, 5'd3, 5'd6, 0, 1);
            #1 chk("hold_stall", 64'(stall_id), (i == 1) ? 64'd1 : 64'd0);
            tick();
            chk("hold_pc", 64'(ex_pc_4), 64'h040);
            chk("hold_valid", 64'(ex_valid), 1);
        end
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 64'(ex_valid), 0);
        chk("arst_pc", 64'(ex_pc_4), 0);
        chk("arst_a", 64'(ex_rf_data_a), 0);
        chk("arst_mr", 64'(ex_ctl_mem_read), 0);
        chk("arst_cnt", 64'(cnt_bubble), 0);
        tick();
        rst_n = 1'b1; en = 1'b1;
        drive(1, 32'h050, 32'h4321, 5'd1, 5'd2, 5'd7, 0, 1);
        tick();
        chk("resume_pc", 64'(ex_pc_4), 64'h050);
        chk("resume_valid", 64'(ex_valid), 1);

        // Counter saturation under repeated flushes.
        ex_branched = 1'b1;
`ifdef PIPE_STAT_EN
        for (int i = 0; i < 65537; i++) tick();
        chk("sat_cnt", 64'(cnt_bubble), 64'hFFFF);
`else
        for (int i = 0; i < 20; i++) tick();
        chk("nostat_cnt", 64'(cnt_bubble), 0);
`endif
        ex_branched = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_id_ex.md
PIPE_ID_EX -- requirements
Module: pipe_id_ex

Interface
REQ-001 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have port en  input  1  global pipeline enable; low holds all state.
REQ-004 SHALL have port id_valid  input  1  decode slot holds a real instruction.
REQ-005 SHALL have ports id_pc_4 (`IM_ADDR_BIT), id_shamt (5), id_imm16 (16), id_rf_data_a (32), id_rf_data_b (32)  input  decode-stage operands.
REQ-006 SHALL have ports id_ctl_alu_op (`ALU_OP_BIT), id_ctl_wtg_op (`WTG_OP_BIT), id_ctl_syscall_en (1), id_mux_alu_data_y (`MUX_ALU_DATAY_BIT), id_ctl_mem_read (1), id_ctl_rf_we (1)  input  decode control.
REQ-007 SHALL have ports id_rs, id_rt, id_rd_dst  input  5 each  source and destination register numbers.
REQ-008 SHALL have port ex_branched  input  1  execute stage resolved a taken branch/jump this cycle.
REQ-009 SHALL have registered outputs ex_valid (1) and ex_<field> for every id_<field> of REQ-005..REQ-007, same widths.
REQ-010 SHALL have port stall_id  output  1  combinational load-use stall request to fetch/decode.
REQ-011 SHALL have port cnt_bubble  output  16  bubbles inserted since reset.

Function
REQ-012 SHALL, on each rising clk with en=1, select exactly one action by priority: flush > stall > advance.
REQ-013 Flush (ex_branched=1) SHALL set ex_valid=0 and all ex_ctl_* and ex_mux_alu_data_y to 0; data and register-number outputs SHALL hold.
REQ-014 stall_id SHALL equal id_valid & ex_valid & ex_ctl_mem_read & (ex_rd_dst!=0) & (ex_rd_dst==id_rs | ex_rd_dst==id_rt).
REQ-015 Stall (stall_id=1, no flush) SHALL insert a bubble identical to REQ-013; upstream holds the decode slot.
REQ-016 Advance SHALL copy every id_* input to its ex_* output and id_valid to ex_valid, latency one cycle.
REQ-017 Control encoding 0 on every ctl field SHALL be a no-op (no ALU side effect, no branch, no syscall, no memory or register write).
REQ-018 stall_id SHALL last at most one cycle per load-use hazard, since the bubble clears ex_ctl_mem_read.
REQ-019 With en=0, all outputs except stall_id SHALL hold; stall_id SHALL still be evaluated from current values.
REQ-020 ex_branched and stall_id both high SHALL produce one bubble only; cnt_bubble increments by 1.
REQ-021 Register $0 as destination (id_rd_dst=0) SHALL never cause a stall.

Reset
REQ-022 rst_n low SHALL immediately clear ex_valid, every ex_* output and cnt_bubble to 0, regardless of clk or en.
REQ-023 Deasserting rst_n mid-operation SHALL resume with an empty EX slot; first edge with en=1 performs advance.

Configuration
REQ-024 Macro PIPE_STAT_EN SHALL control the bubble counter.
REQ-025 Defined: cnt_bubble SHALL increment by 1 on each edge with en=1 that performs flush or stall, saturating at 16'hFFFF.
REQ-026 Undefined: cnt_bubble SHALL be constant 0, no counter register inferred; all other behaviour unchanged.

Verification
REQ-027 Reset then advance id_pc_4=0x010, id_rf_data_a=0x1234, id_valid=1 -> next cycle ex_pc_4=0x010, ex_rf_data_a=0x1234, ex_valid=1.
REQ-028 EX holds load (mem_read=1, rd_dst=8, valid=1); id_rs=8 -> stall_id=1; next edge ex_valid=0, ctl zero; stall_id=0; cnt_bubble=1.
REQ-029 Same as REQ-028 but rd_dst=0 -> stall_id=0, instruction advances, cnt_bubble unchanged.
REQ-030 ex_branched=1 with id_ctl_syscall_en=1 -> next cycle ex_valid=0, ex_ctl_syscall_en=0, ex_ctl_wtg_op=0.
REQ-031 en=0 for 3 cycles with changing inputs -> outputs unchanged; rst_n pulse mid-hold -> all outputs 0 immediately.
REQ-032 With PIPE_STAT_EN, force 65537 flushes -> cnt_bubble=16'hFFFF; without macro -> cnt_bubble=0.
